// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding
// and the default operand width.
package serial_add_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter must be able to hold WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// One-bit full adder; the only arithmetic element of the serial adder.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures A, B and carry-in, adds one bit pair
// per clock LSB first through a single full adder, then presents the result.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             busy_o
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               c_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               fa_s, fa_co;
  logic               last_bit;

  fulladder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets its default before the case so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid_i)  state_d = ST_RUN;
      ST_RUN:  if (last_bit)    state_d = ST_DONE;
      ST_DONE: if (out_ready_i) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // a_q doubles as the result shift register: each operand bit consumed at
  // the LSB end frees a slot for the new sum bit at the MSB end.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            c_q   <= carry_i;
            cnt_q <= '0;
          end
        end
        ST_RUN: begin
          a_q   <= {fa_s, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          c_q   <= fa_co;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            sum_q   <= {fa_s, a_q[WIDTH-1:1]};
            carry_q <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign busy_o      = (state_q == ST_RUN);
  assign out_valid_o = (state_q == ST_DONE);
  assign sum_o       = sum_q;
  assign carry_o     = carry_q;

endmodule
